// File: rtl/demux_stage.sv
// One-entry holding stage that steers each word to the msb or lsb consumer by its
// destination bit, with saturating per-side delivery counters.
module demux_stage #(
  parameter int nbits = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [nbits-1:0] in_data,
  input  logic             in_dec,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [nbits-1:0] msb_data,
  output logic             msb_valid,
  input  logic             msb_ready,
  output logic [nbits-1:0] lsb_data,
  output logic             lsb_valid,
  input  logic             lsb_ready,
  output logic [7:0]       msb_count,
  output logic [7:0]       lsb_count
);

  logic [nbits-1:0] hold_data;
  logic             hold_dec;
  logic             hold_valid;
  logic             sel_ready;
  logic             in_xfer;
  logic             msb_xfer;
  logic             lsb_xfer;

  // Outputs are masked while reset is high so the held word can never transfer
  // during the reset cycle and the block looks empty immediately.
  always_comb begin
    sel_ready = hold_dec ? msb_ready : lsb_ready;
    msb_valid = hold_valid & hold_dec & ~reset;
    lsb_valid = hold_valid & ~hold_dec & ~reset;
    msb_data  = msb_valid ? hold_data : '0;
    lsb_data  = lsb_valid ? hold_data : '0;
    in_ready  = reset | ~hold_valid | sel_ready;
    in_xfer   = in_valid & in_ready & ~reset;
    msb_xfer  = msb_valid & msb_ready;
    lsb_xfer  = lsb_valid & lsb_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_dec   <= 1'b0;
      hold_data  <= '0;
    end else if (in_xfer) begin
      hold_valid <= 1'b1;
      hold_dec   <= in_dec;
      hold_data  <= in_data;
    end else if (msb_xfer || lsb_xfer) begin
      hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      msb_count <= '0;
      lsb_count <= '0;
    end else begin
      if (msb_xfer && (msb_count != '1))
        msb_count <= msb_count + 8'd1;
      if (lsb_xfer && (lsb_count != '1))
        lsb_count <= lsb_count + 8'd1;
    end
  end

endmodule

// File: doc/demux_stage.md
DEMUX_STAGE -- requirements
Module: demux_stage

Interface
REQ-001 Parameter: nbits, default 7, width of the data path.
REQ-002 The block SHALL provide the following ports, one per line (clock and reset first):
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  nbits  upstream data word.
- in_dec  input  1  destination select; 1 routes to msb side, 0 routes to lsb side.
- in_valid  input  1  upstream word present.
- in_ready  output  1  block accepts the word this cycle.
- msb_data  output  nbits  data for the msb side.
- msb_valid  output  1  msb side word present.
- msb_ready  input  1  msb consumer accepts.
- lsb_data  output  nbits  data for the lsb side.
- lsb_valid  output  1  lsb side word present.
- lsb_ready  input  1  lsb consumer accepts.
- msb_count  output  8  number of words delivered to the msb side, saturating.
- lsb_count  output  8  number of words delivered to the lsb side, saturating.

Function
REQ-003 The block SHALL contain one holding register: hold_data (nbits), hold_dec (1 bit) and hold_valid (1 bit).
REQ-004 Input transfer: occurs in any cycle where in_valid and in_ready are both 1; in_data and in_dec are captured into the holding register at that edge.
REQ-005 in_ready SHALL be combinational: 1 when hold_valid=0, or when the side addressed by hold_dec has ready=1 in the same cycle.
REQ-006 Output transfer: occurs on the msb side when msb_valid and msb_ready are both 1, and on the lsb side when lsb_valid and lsb_ready are both 1.
REQ-007 Side flags:
- msb_valid = hold_valid AND hold_dec.
- lsb_valid = hold_valid AND NOT hold_dec.
- At most one side is valid in any cycle.
REQ-008 Data outputs:
- The selected side's data SHALL equal hold_data.
- The non-selected side's data SHALL be all zeros.
- When hold_valid=0, both data outputs SHALL be all zeros.
REQ-009 Latency SHALL be exactly 1 cycle from input transfer to the corresponding side valid.
REQ-010 Throughput SHALL be 1 word per cycle while the addressed consumer holds ready=1.
REQ-011 Same-cycle output transfer and input transfer: the holding register SHALL load the new word, and hold_valid SHALL remain 1.
REQ-012 Output transfer with no input transfer SHALL clear hold_valid at that edge.
REQ-013 Head-of-line blocking: while the held word's side is not ready, in_ready SHALL be 0 regardless of in_dec; no reordering and no bypass to the other side.
REQ-014 While a side's valid is 1 and its ready is 0, that side's data and valid SHALL stay stable.
REQ-015 Ready on the non-addressed side SHALL have no effect.
REQ-016 in_dec and in_data SHALL be ignored when in_valid=0.
REQ-017 Counters: msb_count increments by 1 on each msb output transfer, and lsb_count on each lsb output transfer; each saturates at 255 and never wraps.
REQ-018 Counters SHALL be registered outputs that update at the same edge as the transfer.

Reset
REQ-019 When reset=1 at a rising edge, the block SHALL set hold_valid=0, hold_dec=0, hold_data=0, msb_count=0 and lsb_count=0.
REQ-020 During reset, in_ready SHALL be 1, and both valids and both data outputs SHALL be 0.
REQ-021 Reset asserted mid-operation SHALL discard the held word without any output transfer, and SHALL not increment either counter.

Verification
REQ-022 Single word: after reset, in_data=7'h55, in_dec=1, in_valid=1 for 1 cycle, msb_ready=1 -> next cycle msb_valid=1, msb_data=7'h55, lsb_valid=0, lsb_data=0; following cycle msb_count=1.
REQ-023 Back-to-back alternating: words 1,2,3,4 with in_dec=0,1,0,1, both readies=1 -> lsb receives 1,3 and msb receives 2,4, one word per cycle, in_ready constantly 1; final counts lsb=2, msb=2.
REQ-024 Stall/HOL: hold word 7'h0A with in_dec=1, msb_ready=0, next input in_dec=0 valid -> in_ready=0 and msb_data stable at 7'h0A; raise msb_ready -> the 7'h0A transfer and the next input capture occur at the same edge.
REQ-025 Saturation: 260 transfers to lsb -> lsb_count holds 255, and msb_count stays 0.
REQ-026 Reset mid-operation: word held with lsb_ready=0, assert reset for 1 cycle -> lsb_valid=0, counts=0, in_ready=1 next cycle, and no spurious transfer.
